// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: sub_a - sub_b - sub_borrow_in, one full-adder step per clock, LSB first.
// Define SERIAL_SUB_OVERFLOW_EN to add the registered signed-overflow output sub_overflow.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sub_in_valid,
    output logic             sub_in_ready,
    input  logic [WIDTH-1:0] sub_a,
    input  logic [WIDTH-1:0] sub_b,
    input  logic             sub_borrow_in,
    output logic             sub_out_valid,
    input  logic             sub_out_ready,
    output logic [WIDTH-1:0] sub_diff,
    output logic             sub_borrow_out,
`ifdef SERIAL_SUB_OVERFLOW_EN
    output logic             sub_overflow,
`endif
    output logic             sub_busy
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] shift_a_q, shift_a_d;
    logic [WIDTH-1:0] shift_nb_q, shift_nb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             oval_q, oval_d;
    logic             sum_bit;
    logic             carry_out;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             ovf_q, ovf_d;
`endif

    function automatic logic maj(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    always_comb begin
        sum_bit    = shift_a_q[0] ^ shift_nb_q[0] ^ carry_q;
        carry_out  = maj(shift_a_q[0], shift_nb_q[0], carry_q);
        state_d    = state_q;
        cnt_d      = cnt_q;
        carry_d    = carry_q;
        shift_a_d  = shift_a_q;
        shift_nb_d = shift_nb_q;
        res_d      = res_q;
        diff_d     = diff_q;
        bout_d     = bout_q;
        oval_d     = oval_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
        ovf_d      = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                // Subtraction as a + ~b + ~borrow_in on a single adder cell.
                if (sub_in_valid) begin
                    shift_a_d  = sub_a;
                    shift_nb_d = ~sub_b;
                    carry_d    = ~sub_borrow_in;
                    cnt_d      = '0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                carry_d        = carry_out;
                shift_a_d      = shift_a_q >> 1;
                shift_nb_d     = shift_nb_q >> 1;
                res_d          = res_q >> 1;
                res_d[WIDTH-1] = sum_bit;
                cnt_d          = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    diff_d  = res_d;
                    bout_d  = ~carry_out;
                    oval_d  = 1'b1;
                    state_d = DONE;
`ifdef SERIAL_SUB_OVERFLOW_EN
                    // carry_q is the carry into the MSB on this final step.
                    ovf_d   = carry_q ^ carry_out;
`endif
                end
            end
            DONE: begin
                if (sub_out_ready) begin
                    oval_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            oval_q  <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            oval_q  <= oval_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Operand and partial-result shifters are fully rewritten before use, so they carry no reset.
    always_ff @(posedge clk) begin
        shift_a_q  <= shift_a_d;
        shift_nb_q <= shift_nb_d;
        res_q      <= res_d;
    end

    assign sub_in_ready   = (state_q == IDLE);
    assign sub_busy       = (state_q != IDLE);
    assign sub_out_valid  = oval_q;
    assign sub_diff       = diff_q;
    assign sub_borrow_out = bout_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    assign sub_overflow   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: a WIDTH=8 instance and a WIDTH=1 instance.
module tb_serial_subtractor;
    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready, bin, bout, busy;
    logic [W-1:0] a, b, diff;
    logic         v1, r1, ov1, or1, bin1, bout1, busy1;
    logic [0:0]   a1, b1, d1;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic         ovf, ovf1;
`endif

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        int           acc;
    } exp_t;

    exp_t q8[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   rnd_rdy = 0;
    bit   seen8 = 0;
    bit   seen1 = 0;

    serial_subtractor #(.WIDTH(W)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .sub_in_valid(in_valid), .sub_in_ready(in_ready),
        .sub_a(a), .sub_b(b), .sub_borrow_in(bin),
        .sub_out_valid(out_valid), .sub_out_ready(out_ready),
        .sub_diff(diff), .sub_borrow_out(bout),
`ifdef SERIAL_SUB_OVERFLOW_EN
        .sub_overflow(ovf),
`endif
        .sub_busy(busy)
    );

    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .sub_in_valid(v1), .sub_in_ready(r1),
        .sub_a(a1), .sub_b(b1), .sub_borrow_in(bin1),
        .sub_out_valid(ov1), .sub_out_ready(or1),
        .sub_diff(d1), .sub_borrow_out(bout1),
`ifdef SERIAL_SUB_OVERFLOW_EN
        .sub_overflow(ovf1),
`endif
        .sub_busy(busy1)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operands.
    function automatic exp_t model(input int w, input int x, input int y, input int bi, input int acc);
        exp_t e;
        int m, r, sx, sy, sr;
        m     = 1 << w;
        r     = x - y - bi;
        e.bo  = (r < 0);
        e.d   = W'((r + m) % m);
        sx    = (x >= m / 2) ? x - m : x;
        sy    = (y >= m / 2) ? y - m : y;
        sr    = sx - sy - bi;
        e.ov  = (sr < -(m / 2)) || (sr > (m / 2) - 1);
        e.acc = acc;
        return e;
    endfunction

    // Called #1 after a rising edge; returns #1 after the accept edge.
    task automatic issue8(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi, input bit track);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_wait8", in_ready, 1);
        if (in_ready) begin
            a = x; b = y; bin = bi; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
            if (track) q8.push_back(model(W, int'(x), int'(y), int'(bi), cyc));
        end
    endtask

    task automatic issue1(input logic x, input logic y, input logic bi);
        int n = 0;
        while (!r1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_wait1", r1, 1);
        if (r1) begin
            a1 = x; b1 = y; bin1 = bi; v1 = 1'b1;
            @(posedge clk); #1;
            v1 = 1'b0;
            chk("busy1", busy1, 1);
            q1.push_back(model(1, int'(x), int'(y), int'(bi), cyc));
        end
    endtask

    // Monitor for the WIDTH=8 instance: pops on each output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && !seen8) begin
                seen8 = 1;
                if (q8.size() != 0) chk("latency8", cyc - q8[0].acc, W);
            end
            if (rst_n && out_valid && out_ready) begin
                if (q8.size() == 0) chk("unexpected_out8", q8.size(), 1);
                else begin
                    e = q8.pop_front();
                    chk("diff8", diff, e.d);
                    chk("borrow8", bout, e.bo);
`ifdef SERIAL_SUB_OVERFLOW_EN
                    chk("ovf8", ovf, e.ov);
`endif
                end
                seen8 = 0;
            end
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && ov1 && !seen1) begin
                seen1 = 1;
                if (q1.size() != 0) chk("latency1", cyc - q1[0].acc, 1);
            end
            if (rst_n && ov1 && or1) begin
                if (q1.size() == 0) chk("unexpected_out1", q1.size(), 1);
                else begin
                    e = q1.pop_front();
                    chk("diff1", d1, e.d);
                    chk("borrow1", bout1, e.bo);
`ifdef SERIAL_SUB_OVERFLOW_EN
                    chk("ovf1", ovf1, e.ov);
`endif
                end
                seen1 = 0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] held;
        int n;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; bin = 1'b0;
        v1 = 1'b0; or1 = 1'b1; a1 = '0; b1 = '0; bin1 = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_diff", diff, 0);
        chk("rst_borrow", bout, 0);
        chk("rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        issue8(8'h5A, 8'h23, 1'b0, 1);
        issue8(8'h10, 8'h20, 1'b0, 1);
        issue8(8'h00, 8'h00, 1'b1, 1);
        issue8(8'h80, 8'h01, 1'b0, 1);
        issue8(8'h7F, 8'hFF, 1'b0, 1);
        issue8(8'hFF, 8'hFF, 1'b1, 1);
        issue8(8'h00, 8'hFF, 1'b0, 1);

        rnd_rdy = 1;
        for (int i = 0; i < 40; i++) issue8(W'($urandom), W'($urandom), 1'($urandom), 1);
        rnd_rdy = 0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        repeat (W + 3) @(posedge clk);
        #1 out_ready = 1'b0;

        // Consumer stalls in DONE while new operands are offered.
        issue8(8'hC3, 8'h3C, 1'b0, 1);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("hold_valid_rise", out_valid, 1);
        held = diff;
        for (int i = 0; i < 5; i++) begin
            a = W'($urandom); b = W'($urandom); in_valid = 1'b1;
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_diff", diff, held);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_busy", busy, 1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_in_ready", in_ready, 1);
        chk("post_out_valid", out_valid, 0);
        chk("post_diff_kept", diff, 8'h87);

        // Asynchronous reset during the third SHIFT cycle.
        issue8(8'hAA, 8'h11, 1'b0, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midshift_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("areset_out_valid", out_valid, 0);
        chk("areset_diff", diff, 0);
        chk("areset_borrow", bout, 0);
        chk("areset_busy", busy, 0);
        chk("areset_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue8(8'h05, 8'h03, 1'b0, 1);

        for (int i = 0; i < 8; i++) issue1(1'(i >> 2), 1'(i >> 1), 1'(i));

        n = 0;
        while ((q8.size() != 0 || q1.size() != 0) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain8", q8.size(), 0);
        chk("drain1", q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
